tri_rom_sched: RTL
==================

# tri_rom_sched

Scheduler that shares one single-port 256×8 waveform ROM between the left and right audio channels. It replaces free-running per-channel address counters with a single-clock sequencer that owns both channels' phase accumulators. On each sample tick it issues the left read, then the right read. It delivers registered samples with one-cycle valid strobes. It sits between the sample-rate tick generator and the ROM/DAC serializer.

## Interface
- ADDR_W, 8, ROM address width; phase accumulators are ADDR_W bits.
- DATA_W, 8, ROM data / sample width.
- ROM_LAT, 1, ROM read latency in cycles. Legal range 1..3. rom_data is valid ROM_LAT cycles after the rom_en cycle.

- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse requesting one L/R sample pair.
- step_l  in  ADDR_W  left phase increment, sampled at tick acceptance.
- step_r  in  ADDR_W  right phase increment, sampled at tick acceptance.
- overrun_clr  in  1  clears the sticky overrun flag.
- rom_addr  out  ADDR_W  ROM address, meaningful only while rom_en=1.
- rom_en  out  1  ROM read strobe, one cycle per read.
- rom_data  in  DATA_W  ROM read data.
- sample_l  out  DATA_W  last left sample, held between updates.
- sample_r  out  DATA_W  last right sample, held between updates.
- valid_l  out  1  one-cycle pulse when sample_l updates.
- valid_r  out  1  one-cycle pulse when sample_r updates.
- busy  out  1  high whenever FSM is not IDLE.
- overrun  out  1  sticky flag: a tick arrived while busy.

## Operation
- FSM states: IDLE, RD_L, WT_L, RD_R, WT_R.
- IDLE: sample_tick=1 latches step_l and step_r, then moves to RD_L. Otherwise the FSM stays in IDLE.
- RD_L: 1 cycle. rom_en=1, rom_addr=phase_l. Next state is WT_L.
- WT_L: ROM_LAT cycles, counted by an internal 2-bit counter. On the last cycle the block captures rom_data into sample_l and sets phase_l ← (phase_l + step_l) mod 2^ADDR_W. Next state is RD_R.
- RD_R: 1 cycle. rom_en=1, rom_addr=phase_r. Next state is WT_R.
- WT_R: ROM_LAT cycles, same as WT_L but for the right channel. Next state is IDLE.
- Phase arithmetic is pure modulo 2^ADDR_W, with no clamp or reset-to-zero. Examples: 255+2 → 1; step 0 holds the phase.
- A sample_tick in any non-IDLE state is dropped and sets overrun. The in-flight sequence is unaffected.
- overrun_clr clears overrun. If set and clear occur in the same cycle, set wins.
- rom_en is never high in two consecutive cycles. rom_addr holds 0 when rom_en=0.

## Timing
- Tick accepted at the edge ending cycle 0. Then:
  - rom_en for left in cycle 1.
  - valid_l and new sample_l in cycle 2+ROM_LAT.
  - rom_en for right in cycle 2+ROM_LAT, the same cycle as valid_l.
  - valid_r and new sample_r in cycle 3+2·ROM_LAT.
- busy is high from cycle 1 through cycle 2+2·ROM_LAT.
- The FSM is in IDLE in cycle 3+2·ROM_LAT, so a tick in that cycle is accepted.
- Minimum accepted tick period is 3+2·ROM_LAT cycles (5 for ROM_LAT=1).
- Reset values: rom_addr=0, rom_en=0, sample_l=0, sample_r=0, valid_l=0, valid_r=0, busy=0, overrun=0, phase_l=0, phase_r=0, state=IDLE.
- Reset asserted mid-sequence aborts immediately and asynchronously. No partial capture occurs. The first tick after reset release reads address 0 for both channels.

## Configuration
- TRI_SCHED_HALF_ROM_EN defined: the ROM holds only the rising half of the waveform (2^(ADDR_W-1) entries).
  - Physical address = phase when phase MSB=0.
  - Physical address = ~phase when phase MSB=1, i.e. 2^ADDR_W−1−phase.
  - rom_addr MSB is always 0. Example: phase 200 → addr 55.
- Not defined: rom_addr = phase directly, using the full 2^ADDR_W-entry ROM.
- Timing is identical in both builds.

## Structure
- Package tri_sched_pkg holds:
  - the state enum (IDLE, RD_L, WT_L, RD_R, WT_R);
  - ROM_LAT_MIN=1 and ROM_LAT_MAX=3;
  - the default widths.
- Sub-module tri_phase_acc: one ADDR_W-bit accumulator with load-step, advance and async clear, plus the phase→ROM address mapping (mirror under TRI_SCHED_HALF_ROM_EN). It is instantiated twice, once for L and once for R.
- The FSM, latency counter, capture registers and overrun logic live in the top module.

## Test plan
- Reset, ROM_LAT=1, ROM model data=addr, step_l=1, step_r=2, ticks every 5 cycles → rom_addr sequence 0,0,1,2,2,4,…; valid_l in cycle 3 and valid_r in cycle 5 after each tick; sample_l=0,1,2, sample_r=0,2,4.
- step_r=2 held for 128 ticks, starting from phase_r 254 → the next read is addr 0 (254+2 wraps to 0), never clamped.
- Ticks spaced 3 cycles apart, ROM_LAT=1 → the second tick is ignored and overrun=1 until overrun_clr. overrun_clr pulsed together with a new overrun → overrun stays 1.
- rst_n asserted in WT_L → all outputs 0 immediately; after release, a tick reads address 0 with valid_l/valid_r at the nominal cycles.
- ROM_LAT=3 → valid_l in cycle 5, valid_r in cycle 9; busy spans cycles 1–8; a tick in cycle 9 is accepted.
- TRI_SCHED_HALF_ROM_EN, step_l=100 → rom_addr for L: 0, 100, 55 (phase 200), 44 (phase 44).

Source files
------------

// File: rtl/tri_sched_pkg.sv
// Shared types and constants for the L/R waveform ROM scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tri_sched_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 8;
   localparam int ROM_LAT_MIN = 1;
   localparam int ROM_LAT_MAX = 3;

   typedef enum logic [2:0] {
      IDLE,
      RD_L,
      WT_L,
      RD_R,
      WT_R
   } state_t;

endpackage

// File: rtl/tri_phase_acc.sv
// One channel phase accumulator plus phase-to-ROM-address mapping.
// Latency: addr follows phase combinationally; phase moves one cycle after advance.
// Backpressure: none; load and advance are strobes from the scheduler FSM.
// Ports: clk/rst_n; load latches step; advance adds the latched step (mod 2^ADDR_W);
//        addr is the physical ROM address for the current phase.
// Build option: TRI_SCHED_HALF_ROM_EN mirrors the upper half of the phase circle
//        onto a half-size ROM holding only the rising half of the waveform.
module tri_phase_acc
   import tri_sched_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] step,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] step_q;
   logic [ADDR_W-1:0] phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
         phase  <= '0;
      end else begin
         if (load) begin
            step_q <= step;
         end
         // Plain modulo wrap: the adder simply drops the carry.
         if (advance) begin
            phase <= phase + step_q;
         end
      end
   end

`ifdef TRI_SCHED_HALF_ROM_EN
   // Upper half of the circle reads the table backwards: ~phase == 2^ADDR_W-1-phase,
   // which also forces the address MSB to 0.
   assign addr = phase[ADDR_W-1] ? ~phase : phase;
`else
   assign addr = phase;
`endif

endmodule

// File: rtl/tri_rom_sched.sv
// Shares one single-port waveform ROM between L and R: per tick reads L then R.
// Latency: L sample 2+ROM_LAT cycles after tick accept, R sample 3+2*ROM_LAT.
// Backpressure: none; ticks arriving while busy are dropped and flagged in overrun.
// Ports: sample_tick/step_l/step_r request a sample pair; rom_en/rom_addr/rom_data
//        talk to the ROM (data ROM_LAT cycles after rom_en); sample_l/r + valid_l/r
//        deliver samples; busy = FSM not idle; overrun is sticky until overrun_clr.
// Build option: TRI_SCHED_HALF_ROM_EN (see tri_phase_acc) selects half-size ROM mapping.
module tri_rom_sched
   import tri_sched_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROM_LAT = ROM_LAT_MIN   // legal ROM_LAT_MIN..ROM_LAT_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_tick,
   input  logic [ADDR_W-1:0] step_l,
   input  logic [ADDR_W-1:0] step_r,
   input  logic              overrun_clr,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample_l,
   output logic [DATA_W-1:0] sample_r,
   output logic              valid_l,
   output logic              valid_r,
   output logic              busy,
   output logic              overrun
);

   // The wait counter runs 0..ROM_LAT-1; the last count is the cycle rom_data is valid.
   localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

   state_t            state;
   logic [1:0]        lat_cnt;
   logic              lat_done;
   logic              tick_ok;
   logic              adv_l;
   logic              adv_r;
   logic [ADDR_W-1:0] addr_l;
   logic [ADDR_W-1:0] addr_r;

   assign lat_done = (lat_cnt == LAT_LAST);
   assign tick_ok  = sample_tick && (state == IDLE);
   assign adv_l    = (state == WT_L) && lat_done;
   assign adv_r    = (state == WT_R) && lat_done;

   // Both channels latch their step on the accepted tick so a step change mid-sequence
   // cannot split a sample pair across two different increments.
   tri_phase_acc #(.ADDR_W(ADDR_W)) u_acc_l (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tick_ok),
      .step    (step_l),
      .advance (adv_l),
      .addr    (addr_l)
   );

   tri_phase_acc #(.ADDR_W(ADDR_W)) u_acc_r (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tick_ok),
      .step    (step_r),
      .advance (adv_r),
      .addr    (addr_r)
   );

   // rom_en/rom_addr are registered on the transition into RD_x so they line up with
   // the RD_x cycle; the R read is launched in the same edge that captures L.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         rom_en   <= 1'b0;
         rom_addr <= '0;
         sample_l <= '0;
         sample_r <= '0;
         valid_l  <= 1'b0;
         valid_r  <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rom_en   <= 1'b0;
         rom_addr <= '0;
         valid_l  <= 1'b0;
         valid_r  <= 1'b0;

         // A new overrun beats a simultaneous clear.
         if (sample_tick && (state != IDLE)) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (sample_tick) begin
                  state    <= RD_L;
                  busy     <= 1'b1;
                  rom_en   <= 1'b1;
                  rom_addr <= addr_l;
               end
            end
            RD_L: begin
               state   <= WT_L;
               lat_cnt <= '0;
            end
            WT_L: begin
               if (lat_done) begin
                  sample_l <= rom_data;
                  valid_l  <= 1'b1;
                  state    <= RD_R;
                  rom_en   <= 1'b1;
                  rom_addr <= addr_r;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            RD_R: begin
               state   <= WT_R;
               lat_cnt <= '0;
            end
            WT_R: begin
               if (lat_done) begin
                  sample_r <= rom_data;
                  valid_r  <= 1'b1;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
